ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port 16-bit RAM between two requesters: port 0 (CPU fetch/execute) and port 1 (loader/debug).
//  Uses a per-port REQ/ACK handshake, latches the winning command and drives the RAM's LOAD/ADDRESS/DATA_IN.
//  Captures DATA_OUT into a per-port read register.
//  Sits between the CPU core/loader and the RAM instance; one access every 3 cycles.
// PARAMETERS
//  ADDR_WIDTH  16  RAM address width
//  DATA_WIDTH  16  RAM word width
// PORTS
//  CLK          in   1           system clock, all state on posedge
//  RESET        in   1           synchronous, active-high reset
//  REQ0/REQ1    in   1           access request, port 0 / port 1
//  WE0/WE1      in   1           1 = write, 0 = read; valid while REQn=1
//  ADDR0/ADDR1  in   ADDR_WIDTH  access address
//  WDATA0/1     in   DATA_WIDTH  write data
//  ACK0/ACK1    out  1           one-cycle completion pulse
//  RDATA0/1     out  DATA_WIDTH  read data; valid with ACKn, held until next read ACK on that port
//  GRANT        out  2           one-hot owner of the access in flight (bit n = port n)
//  RAM_LOAD     out  1           to RAM LOAD
//  RAM_ADDRESS  out  ADDR_WIDTH  to RAM ADDRESS
//  RAM_DATA_IN  out  DATA_WIDTH  to RAM DATA_IN
//  RAM_DATA_OUT in   DATA_WIDTH  from RAM DATA_OUT (combinational read)
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; GRANT=0; ACK0=ACK1=0; RDATA0=RDATA1=0
//   - latched addr/wdata/we=0; LAST=1, so port 0 wins the first contention.
//  FSM IDLE -> ACCESS -> DONE -> IDLE:
//   - IDLE: stays while no REQ.
//     - If any REQn=1 at edge T: pick winner, latch ADDR/WE/WDATA, set GRANT, go ACCESS.
//   - ACCESS (T+1):
//     - RAM_ADDRESS/RAM_DATA_IN come from the latched command.
//     - RAM_LOAD = latched WE & ~RESET, so the write commits at the end of T+1.
//     - On a read, RDATAn <= RAM_DATA_OUT at the same edge.
//     - ACKn <= 1; go DONE.
//   - DONE (T+2): ACKn=1 for exactly this cycle; all REQs ignored; GRANT=0 next; go IDLE.
//  Latency: REQ seen -> ACK = 2 cycles. Throughput: one access per 3 cycles.
//  Handshake:
//   - Requester holds REQ/WE/ADDR/WDATA stable until it sees ACK.
//   - Requester may drop REQ or present a new command from the cycle after ACK.
//   - REQ dropped before grant: request withdrawn, no access.
//   - Input changes after the IDLE latch edge have no effect on the access in flight.
//  Arbitration (default round-robin):
//   - Both REQ in IDLE: grant port != LAST.
//   - Single REQ: granted regardless of LAST.
//   - LAST updates to the winner on every grant.
//  Outside ACCESS: RAM_LOAD=0; RAM_ADDRESS/RAM_DATA_IN hold the last latched values.
//  Write ACK leaves RDATAn unchanged.
//  RESET mid-access:
//   - RESET=1 in ACCESS: no write commits (LOAD gated), no ACK issued.
//   - All registers return to reset values at that edge.
//  Address wraps naturally at 2^ADDR_WIDTH; no bounds checks.
// CONFIGURATION
//  ARB_FIXED_PRIORITY_EN defined: port 0 always wins contention; LAST is unused.
//   - Port 1 can starve; accepted for debug/loader use.
//  Undefined (default): round-robin as above; neither port waits more than one foreign access.
// TESTING
//  1. Port 0 write 0x0010<=0xBEEF, then read 0x0010:
//     - ACK0 two cycles after each REQ; RAM_LOAD high one cycle; RDATA0=0xBEEF.
//  2. REQ0 and REQ1 rise in the same cycle after reset, both reading:
//     - port 0 granted first, then port 1.
//     - Continuous REQs alternate 0,1,0,1 across 8 accesses.
//  3. Port 1 holds REQ continuously (reads 0xFFFF):
//     - ACK1 every 3rd cycle; address wraps correctly with ADDR1=0xFFFF then 0x0000.
//  4. RESET during ACCESS of port 0 write 0x0020<=0x1234:
//     - no ACK0; a later read of 0x0020 returns the prior contents.
//     - All outputs 0 the cycle after reset.
//  5. With ARB_FIXED_PRIORITY_EN, REQ0 and REQ1 held high for 6 accesses:
//     - all 6 ACKs go to port 0; ACK1 only after REQ0 drops.
//  6. Port 0 read 0x0005 (=0xAAAA), then port 0 write 0x0005<=0x5555:
//     - RDATA0 stays 0xAAAA after the write ACK.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port RAM between two requesters (port 0: CPU, port 1:
//   loader/debug) using a per-port REQ/ACK handshake. A winning command is
//   latched in IDLE, driven to the RAM during ACCESS, and acknowledged with a
//   one-cycle ACK in DONE. One access completes every 3 cycles.
//
//   Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (port 0
//   always wins contention). Default is round-robin.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   REQn/WEn/ADDRn/WDATAn  request, write enable, address, write data
//   ACKn                one-cycle completion pulse
//   RDATAn              read data, held until the next read ACK on that port
//   GRANT               one-hot owner of the access in flight
//   RAM_LOAD/RAM_ADDRESS/RAM_DATA_IN  RAM command outputs
//   RAM_DATA_OUT        RAM combinational read data
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] RDATA0,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic [1:0]            GRANT,
    output logic                  RAM_LOAD,
    output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
    output logic [DATA_WIDTH-1:0] RAM_DATA_IN,
    input  logic [DATA_WIDTH-1:0] RAM_DATA_OUT
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  pick1;

`ifdef ARB_FIXED_PRIORITY_EN
    // Port 1 only wins when port 0 is not requesting.
    assign pick1 = ~REQ0;
`else
    // LAST = 1 means port 1 won the previous grant; reset value makes
    // port 0 win the first contention.
    logic last_q, last_d;

    assign pick1 = REQ1 & (~REQ0 | ~last_q);
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifndef ARB_FIXED_PRIORITY_EN
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ0 | REQ1) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    we_d    = pick1 ? WE1 : WE0;
                    addr_d  = pick1 ? ADDR1 : ADDR0;
                    wdata_d = pick1 ? WDATA1 : WDATA0;
`ifndef ARB_FIXED_PRIORITY_EN
                    last_d  = pick1;
`endif
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Read data is captured at the same edge the write would commit.
                if (grant_q[1]) begin
                    ack1_d = 1'b1;
                    if (!we_q) rdata1_d = RAM_DATA_OUT;
                end else begin
                    ack0_d = 1'b1;
                    if (!we_q) rdata0_d = RAM_DATA_OUT;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifndef ARB_FIXED_PRIORITY_EN
            last_q   <= last_d;
`endif
        end
    end

    // RESET gates LOAD combinationally so a reset during ACCESS commits nothing.
    assign RAM_LOAD    = we_q & (state_q == S_ACCESS) & ~RESET;
    assign RAM_ADDRESS = addr_q;
    assign RAM_DATA_IN = wdata_q;
    assign ACK0        = ack0_q;
    assign ACK1        = ack1_q;
    assign RDATA0      = rdata0_q;
    assign RDATA1      = rdata1_q;
    assign GRANT       = grant_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req [2];
    logic        we_r [2];
    logic [15:0] addr_r [2];
    logic [15:0] wdata_r [2];
    logic        ACK0, ACK1, RAM_LOAD;
    logic [15:0] RDATA0, RDATA1, RAM_ADDRESS, RAM_DATA_IN, RAM_DATA_OUT;
    logic [1:0]  GRANT;

    always #5 CLK = ~CLK;

    ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(req[0]), .REQ1(req[1]), .WE0(we_r[0]), .WE1(we_r[1]),
        .ADDR0(addr_r[0]), .ADDR1(addr_r[1]),
        .WDATA0(wdata_r[0]), .WDATA1(wdata_r[1]),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
        .GRANT(GRANT), .RAM_LOAD(RAM_LOAD), .RAM_ADDRESS(RAM_ADDRESS),
        .RAM_DATA_IN(RAM_DATA_IN), .RAM_DATA_OUT(RAM_DATA_OUT)
    );

    // RAM instance stand-in: combinational read, write on posedge with LOAD.
    logic [15:0] ram [0:65535];
    assign RAM_DATA_OUT = ram[RAM_ADDRESS];
    always @(posedge CLK) if (RAM_LOAD) ram[RAM_ADDRESS] <= RAM_DATA_IN;

    // Reference model state (transaction level).
    logic [15:0] ref_mem [0:65535];
    logic [15:0] m_rdata [2];
    int          m_last;      // port that won the previous grant
    int          m_busy;      // edges remaining before the arbiter is free
    int          m_owner;
    logic        m_we;
    logic [15:0] m_addr, m_wdata;
    int          released;    // port whose access finished at this edge, or -1

    typedef struct { int unsigned cyc; logic [1:0] oh; logic [15:0] rdata; } exp_t;
    typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
    exp_t expq [$];
    wr_t  wq [$];

    int unsigned n_checks = 0, n_fail = 0, cycle = 0;
    bit rand_en = 0, hold_mode = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cycle);
        end
    endfunction

    function automatic void fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got none, want event (cycle %0d)", name, cycle);
    endfunction

    // Evaluate the arbitration rules on the inputs present at this edge.
    function automatic void model_edge();
        exp_t e;
        wr_t  w;
        int   win;
        released = -1;
        if (RESET) begin
            m_last = 1; m_busy = 0; m_rdata[0] = '0; m_rdata[1] = '0;
            wq.delete();
            return;
        end
        if (m_busy == 2) begin
            if (m_we) begin
                ref_mem[m_addr] = m_wdata;
            end else begin
                m_rdata[m_owner] = ref_mem[m_addr];
            end
            e.cyc = cycle; e.oh = (m_owner == 1) ? 2'b10 : 2'b01; e.rdata = m_rdata[m_owner];
            expq.push_back(e);
            m_busy = 1;
        end else if (m_busy == 1) begin
            m_busy = 0;
            released = m_owner;
        end else if (req[0] || req[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
            win = req[0] ? 0 : 1;
`else
            if (req[0] && req[1]) win = (m_last == 1) ? 0 : 1;
            else                  win = req[0] ? 0 : 1;
`endif
            m_last = win; m_owner = win; m_busy = 2;
            m_we = we_r[win]; m_addr = addr_r[win]; m_wdata = wdata_r[win];
            if (m_we) begin
                w.addr = m_addr; w.data = m_wdata;
                wq.push_back(w);
            end
        end
    endfunction

    task automatic new_cmd(input int p);
        case ($urandom % 4)
            0: addr_r[p] = 16'h0010 + 16'($urandom % 8);
            1: addr_r[p] = 16'hFFFF;
            2: addr_r[p] = 16'h0000;
            default: addr_r[p] = 16'($urandom);
        endcase
        we_r[p]    = 1'($urandom % 2);
        wdata_r[p] = 16'($urandom);
        req[p]     = 1'b1;
    endtask

    task automatic cyc();
        @(posedge CLK);
        cycle++;
        model_edge();
        #1;
        if (rand_en) begin
            for (int p = 0; p < 2; p++) begin
                if (m_busy > 0 && m_owner == p) continue;
                if (req[p] && released != p) begin
                    if ($urandom % 16 == 0) req[p] = 1'b0;
                end else if ($urandom % 8 < 5) begin
                    new_cmd(p);
                end else begin
                    req[p] = 1'b0;
                end
            end
        end else if (released >= 0 && !hold_mode) begin
            req[released] = 1'b0;
        end
    endtask

    task automatic do_access(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
        bit done = 0;
        we_r[p] = w; addr_r[p] = a; wdata_r[p] = d; req[p] = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            cyc();
            if (released == p) done = 1;
        end
        if (!done) begin
            fail_now("access_timeout");
            req[p] = 1'b0;
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_ack0"}, 32'(ACK0), 0);
        check({tag, "_ack1"}, 32'(ACK1), 0);
        check({tag, "_grant"}, 32'(GRANT), 0);
        check({tag, "_rdata0"}, 32'(RDATA0), 0);
        check({tag, "_rdata1"}, 32'(RDATA1), 0);
        check({tag, "_load"}, 32'(RAM_LOAD), 0);
        check({tag, "_addr"}, 32'(RAM_ADDRESS), 0);
        check({tag, "_din"}, 32'(RAM_DATA_IN), 0);
    endtask

    // Monitor: pops an expectation for every ACK and every RAM write strobe.
    always @(negedge CLK) begin : mon
        exp_t e;
        wr_t  w;
        if (ACK0 === 1'b1 || ACK1 === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_ack", 32'({ACK1, ACK0}), 0);
            end else begin
                e = expq.pop_front();
                check("ack_cycle", cycle, e.cyc);
                check("ack_port", 32'({ACK1, ACK0}), 32'(e.oh));
                check("grant", 32'(GRANT), 32'(e.oh));
                check("rdata", 32'(e.oh[1] ? RDATA1 : RDATA0), 32'(e.rdata));
            end
        end else if (expq.size() > 0 && expq[0].cyc <= cycle) begin
            fail_now("missing_ack");
            void'(expq.pop_front());
        end
        if (RAM_LOAD === 1'b1) begin
            if (wq.size() == 0) begin
                check("unexpected_load", 32'(RAM_LOAD), 0);
            end else begin
                w = wq.pop_front();
                check("ram_addr", 32'(RAM_ADDRESS), 32'(w.addr));
                check("ram_din", 32'(RAM_DATA_IN), 32'(w.data));
            end
        end
    end

    initial begin
        bit got;
        for (int unsigned a = 0; a < 65536; a++) begin
            ram[a]     = 16'(a) ^ 16'h3C96;
            ref_mem[a] = 16'(a) ^ 16'h3C96;
        end
        ram[5] = 16'hAAAA; ref_mem[5] = 16'hAAAA;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we_r[p] = 1'b0; addr_r[p] = '0; wdata_r[p] = '0;
        end
        m_last = 1; m_busy = 0; m_owner = 0; released = -1;
        m_rdata[0] = '0; m_rdata[1] = '0;

        RESET = 1'b1;
        repeat (3) cyc();
        RESET = 1'b0;
        check_all_zero("reset");

        // Write then read back on port 0.
        do_access(0, 1'b1, 16'h0010, 16'hBEEF);
        do_access(0, 1'b0, 16'h0010, 16'h0000);
        check("rdata0_beef", 32'(RDATA0), 32'h0000BEEF);

        // Read then write the same word: write ACK must leave RDATA0 alone.
        do_access(0, 1'b0, 16'h0005, 16'h0000);
        do_access(0, 1'b1, 16'h0005, 16'h5555);
        check("rdata0_kept", 32'(RDATA0), 32'h0000AAAA);

        // Fresh reset, then simultaneous continuous requests from both ports.
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        hold_mode = 1;
        we_r[0] = 1'b0; addr_r[0] = 16'h0040;
        we_r[1] = 1'b0; addr_r[1] = 16'h0041;
        req[0] = 1'b1; req[1] = 1'b1;
        repeat (24) cyc();
        hold_mode = 0;
        if (m_busy == 0) begin req[0] = 1'b0; req[1] = 1'b0; end
        for (int k = 0; k < 6 && (req[0] || req[1]); k++) begin
            cyc();
            if (m_busy == 0) begin req[0] = 1'b0; req[1] = 1'b0; end
        end

        // Port 1 back-to-back reads across the address wrap.
        do_access(1, 1'b0, 16'hFFFF, 16'h0000);
        do_access(1, 1'b0, 16'h0000, 16'h0000);
        do_access(1, 1'b0, 16'hFFFF, 16'h0000);

        // Reset during ACCESS of a port 0 write.
        do_access(0, 1'b1, 16'h0020, 16'h0F0F);
        we_r[0] = 1'b1; addr_r[0] = 16'h0020; wdata_r[0] = 16'h1234; req[0] = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            cyc();
            if (m_busy == 2 && m_owner == 0) got = 1;
        end
        if (!got) fail_now("grant_timeout");
        RESET = 1'b1;
        req[0] = 1'b0;
        cyc();
        RESET = 1'b0;
        check_all_zero("midreset");
        do_access(0, 1'b0, 16'h0020, 16'h0000);
        check("rdata0_prior", 32'(RDATA0), 32'h00000F0F);

        // Randomized traffic on both ports.
        rand_en = 1;
        repeat (3000) cyc();
        rand_en = 0;
        for (int p = 0; p < 2; p++)
            if (!(m_busy > 0 && m_owner == p)) req[p] = 1'b0;
        for (int k = 0; k < 10 && m_busy > 0; k++) cyc();
        repeat (3) cyc();
        check("expq_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
